// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even/odd parity, one stop bit.
// All outputs are registered; TX_DONE/IRQ_Tx report completion of each frame.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [1:0]  PARITY_MODE  = 2'b00
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       TX_START,
  input  logic [7:0] DATA_IN_Tx,
  input  logic       IRQ_CLR,
  output logic       DATA_OUT_Tx,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       IRQ_Tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(CLKS_PER_BIT - 2);
  localparam bit PAR_EN  = (PARITY_MODE == 2'b01) || (PARITY_MODE == 2'b10);
  localparam bit PAR_ODD = (PARITY_MODE == 2'b10);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       tx_byte;
  logic             bit_end, parity;
  logic             line_nxt, busy_nxt, done_nxt;

  assign bit_end = (cnt == '0);
  assign parity  = (^tx_byte) ^ PAR_ODD;

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      tx_byte     <= 8'h00;
      DATA_OUT_Tx <= 1'b1;
      TX_BUSY     <= 1'b0;
      TX_DONE     <= 1'b0;
      IRQ_Tx      <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
      if (state == IDLE && next_state == START) tx_byte <= DATA_IN_Tx;
      DATA_OUT_Tx <= line_nxt;
      TX_BUSY     <= busy_nxt;
      TX_DONE     <= done_nxt;
      // Setting wins over clearing for the whole TX_DONE cycle
      if (done_nxt || TX_DONE) IRQ_Tx <= 1'b1;
      else if (IRQ_CLR)        IRQ_Tx <= 1'b0;
    end
  end

  // STOP runs one cycle short: the TX_DONE cycle in IDLE is the last stop-bit
  // cycle, so a start accepted there follows the stop bit with no gap.
  always_comb begin
    next_state = state;
    cnt_nxt    = cnt - CNT_W'(1);
    idx_nxt    = bit_idx;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (TX_START) begin
          next_state = START;
          cnt_nxt    = CNT_BIT;
        end
      end
      START: begin
        if (bit_end) begin
          next_state = DATA;
          cnt_nxt    = CNT_BIT;
          idx_nxt    = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = CNT_BIT;
          idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (PAR_EN) begin
              next_state = PARITY;
            end else begin
              next_state = STOP;
              cnt_nxt    = CNT_STOP;
            end
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          next_state = STOP;
          cnt_nxt    = CNT_STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          next_state = IDLE;
          cnt_nxt    = '0;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_nxt    = '0;
      end
    endcase
  end

  // Outputs are computed from the upcoming state so the registers line up with it
  always_comb begin
    line_nxt = 1'b1;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (next_state)
      IDLE:    done_nxt = (state == STOP);
      START: begin
        line_nxt = 1'b0;
        busy_nxt = 1'b1;
      end
      DATA: begin
        line_nxt = tx_byte[idx_nxt];
        busy_nxt = 1'b1;
      end
      PARITY: begin
        line_nxt = parity;
        busy_nxt = 1'b1;
      end
      STOP:    busy_nxt = 1'b1;
      default: line_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (no parity, even, odd, mode 2'b11) share one stimulus stream;
// a frame-level reference model feeds per-instance scoreboards and per-cycle output checks.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int NDUT = 4;

  typedef struct packed {
    logic [7:0]  data;
    logic [43:0] vec;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, tx_start, irq_clr;
  logic [7:0]      data_in;
  logic [NDUT-1:0] line, busy, done, irq;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2'b00)) u_none (
    .clk(clk), .RST(rst), .TX_START(tx_start), .DATA_IN_Tx(data_in), .IRQ_CLR(irq_clr),
    .DATA_OUT_Tx(line[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0]), .IRQ_Tx(irq[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2'b01)) u_even (
    .clk(clk), .RST(rst), .TX_START(tx_start), .DATA_IN_Tx(data_in), .IRQ_CLR(irq_clr),
    .DATA_OUT_Tx(line[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1]), .IRQ_Tx(irq[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2'b10)) u_odd (
    .clk(clk), .RST(rst), .TX_START(tx_start), .DATA_IN_Tx(data_in), .IRQ_CLR(irq_clr),
    .DATA_OUT_Tx(line[2]), .TX_BUSY(busy[2]), .TX_DONE(done[2]), .IRQ_Tx(irq[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_MODE(2'b11)) u_m11 (
    .clk(clk), .RST(rst), .TX_START(tx_start), .DATA_IN_Tx(data_in), .IRQ_CLR(irq_clr),
    .DATA_OUT_Tx(line[3]), .TX_BUSY(busy[3]), .TX_DONE(done[3]), .IRQ_Tx(irq[3]));

  int          n_checks = 0;
  int          n_errors = 0;
  bit          live = 1'b0;
  int          m_pos   [NDUT];
  logic [10:0] m_frame [NDUT];
  logic        m_irq   [NDUT];
  logic [43:0] hist    [NDUT];
  frame_t      sb      [NDUT][$];

  function automatic bit has_parity(input int k);
    return (k == 1) || (k == 2);
  endfunction

  function automatic int frame_len(input int k);
    return has_parity(k) ? 11 * CPB : 10 * CPB;
  endfunction

  function automatic logic parity_of(input int k, input logic [7:0] d);
    return (k == 1) ? (^d) : ~(^d);
  endfunction

  // Line samples of a whole frame, most recent (last stop cycle) at bit 0
  function automatic logic [43:0] frame_vec(input int len, input logic [10:0] fr);
    logic [43:0] v;
    v = '0;
    for (int s = 0; s < len; s++) v[len-1-s] = fr[s/CPB];
    return v;
  endfunction

  function automatic bit all_idle();
    for (int k = 0; k < NDUT; k++) if (m_pos[k] >= 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: m_pos is the cycle index within the current frame, -1 when idle
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      int     len;
      logic   done_now;
      frame_t item;
      len      = frame_len(k);
      done_now = (m_pos[k] == len - 1);
      if (rst) begin
        m_pos[k] = -1;
        m_irq[k] = 1'b0;
        sb[k].delete();
      end else begin
        if (tx_start && (m_pos[k] < 0 || done_now)) begin
          m_pos[k]   = 0;
          m_frame[k] = has_parity(k) ? {1'b1, parity_of(k, data_in), data_in, 1'b0}
                                     : {2'b11, data_in, 1'b0};
          item.data  = data_in;
          item.vec   = frame_vec(len, m_frame[k]);
          sb[k].push_back(item);
        end else if (m_pos[k] >= 0 && !done_now) begin
          m_pos[k]++;
        end else begin
          m_pos[k] = -1;
        end
        if (m_pos[k] == len - 1 || done_now) m_irq[k] = 1'b1;
        else if (irq_clr)                     m_irq[k] = 1'b0;
      end
    end
    if (rst) live = 1'b1;
  end

  task automatic check_output(input string name, input int k, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("[TB] FAIL %s dut%0d t=%0t actual=%b expected=%b", name, k, $time, act, exp_v);
    end
  endtask

  task automatic check_frame(input int k, input int len);
    frame_t      item;
    logic [43:0] mask;
    n_checks++;
    if (sb[k].size() == 0) begin
      n_errors++;
      $display("[TB] FAIL frame dut%0d t=%0t actual=TX_DONE expected=no frame pending", k, $time);
    end else begin
      item = sb[k].pop_front();
      mask = (44'd1 << len) - 44'd1;
      if ((hist[k] & mask) !== item.vec) begin
        n_errors++;
        $display("[TB] FAIL frame dut%0d data=%h t=%0t actual=%h expected=%h",
                 k, item.data, $time, hist[k] & mask, item.vec);
      end
    end
  endtask

  // Monitor: per-cycle output checks, and a scoreboard pop on every TX_DONE
  always @(negedge clk) begin
    if (live) begin
      for (int k = 0; k < NDUT; k++) begin
        int   len;
        logic e_line, e_busy, e_done;
        len    = frame_len(k);
        e_busy = (m_pos[k] >= 0) && (m_pos[k] < len - 1);
        e_done = (m_pos[k] == len - 1);
        e_line = (m_pos[k] < 0) ? 1'b1 : m_frame[k][m_pos[k]/CPB];
        check_output("line", k, line[k], e_line);
        check_output("busy", k, busy[k], e_busy);
        check_output("done", k, done[k], e_done);
        check_output("irq",  k, irq[k],  m_irq[k]);
        hist[k] = {hist[k][42:0], line[k]};
        if (done[k] === 1'b1) check_frame(k, len);
      end
    end
  end

  task automatic apply_stimulus(input logic start, input logic [7:0] d, input logic clr);
    @(negedge clk);
    tx_start = start;
    data_in  = d;
    irq_clr  = clr;
  endtask

  task automatic send_byte(input logic [7:0] d);
    apply_stimulus(1'b1, d, 1'b0);
    apply_stimulus(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic wait_all_idle(input int max_cycles);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < max_cycles && !idle; n++) begin
      @(negedge clk);
      idle = all_idle();
    end
    if (!idle) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL idle_timeout t=%0t actual=busy expected=idle within %0d cycles", $time, max_cycles);
    end
  endtask

  task automatic wait_pos(input int k, input int target, input int max_cycles);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < max_cycles && !hit; n++) begin
      @(negedge clk);
      hit = (m_pos[k] == target);
    end
    if (!hit) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL pos_timeout dut%0d t=%0t actual=%0d expected=%0d", k, $time, m_pos[k], target);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    irq_clr  = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send_byte(8'hA5);
    wait_all_idle(200);

    // IRQ_CLR in the TX_DONE cycle leaves IRQ set; the following cycle clears it
    send_byte(8'h3C);
    wait_pos(0, 10 * CPB - 1, 100);
    irq_clr = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    wait_all_idle(200);

    send_byte(8'h5A);
    repeat (10) apply_stimulus(1'b0, 8'($urandom), 1'b0);
    apply_stimulus(1'b1, 8'hFF, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    wait_all_idle(200);

    apply_stimulus(1'b1, 8'h00, 1'b0);
    repeat (47) apply_stimulus(1'b1, 8'hFF, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    wait_all_idle(300);

    // Abort during data bit 3, then a complete frame
    send_byte(8'hC3);
    wait_pos(0, 4 * CPB + 1, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h96);
    wait_all_idle(200);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tx_start = ($urandom_range(0, 5) == 0);
      data_in  = 8'($urandom);
      irq_clr  = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 499) == 0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    wait_all_idle(200);
    repeat (2) @(negedge clk);

    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (sb[k].size() != 0) begin
        n_errors++;
        $display("[TB] FAIL pending dut%0d actual=%0d frames outstanding expected=0", k, sb[k].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
